// File: rtl/mem_write_checker.sv
// Store-sequence monitor for the core's data-memory write port: compares qualifying stores,
// in order, against a run-time loaded table and reports pass/fail with a cause code.
module mem_write_checker #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_EXP     = 4,
    parameter int unsigned IGNORE_EN   = 1,
    parameter int unsigned IGNORE_ADDR = 96,
    parameter int unsigned TIMEOUT     = 1000,
    localparam int unsigned IDX_W      = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
    localparam int unsigned CNT_W      = $clog2(NUM_EXP + 1),
    localparam int unsigned CYC_W      = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              start,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CYC_W-1:0]  cycle_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_done, w_done_nxt;
    logic               r_pass, w_pass_nxt;
    logic               r_fail, w_fail_nxt;
    logic [1:0]         r_code, w_code_nxt;
    logic [CNT_W-1:0]   r_match_cnt, w_match_nxt;
    logic [CYC_W-1:0]   r_cycle_cnt, w_cycle_nxt;

    logic [ADDR_W-1:0]  r_tbl_addr [NUM_EXP];
    logic [DATA_W-1:0]  r_tbl_data [NUM_EXP];

    logic [IDX_W-1:0]   w_idx;
    logic               w_qual;
    logic               w_addr_ok;
    logic               w_data_ok;
    logic               w_last;
    logic               w_tmo;

    // Table has no reset: contents survive reset and are only changed through exp_we.
    always_ff @(posedge clk) begin
        if (exp_we && (r_state != S_RUN) && (32'(exp_idx) < NUM_EXP)) begin
            r_tbl_addr[exp_idx] <= exp_addr;
            r_tbl_data[exp_idx] <= exp_data;
        end
    end

    assign w_idx     = r_match_cnt[IDX_W-1:0];
    assign w_qual    = MemWrite && !((IGNORE_EN != 0) && (DataAdr == ADDR_W'(IGNORE_ADDR)));
    assign w_addr_ok = (DataAdr == r_tbl_addr[w_idx]);
    assign w_data_ok = (WriteData == r_tbl_data[w_idx]);
    assign w_last    = ((32'(r_match_cnt) + 32'd1) == NUM_EXP);
    assign w_tmo     = ((32'(r_cycle_cnt) + 32'd1) >= TIMEOUT);

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_fail_nxt  = r_fail;
        w_code_nxt  = r_code;
        w_match_nxt = r_match_cnt;
        w_cycle_nxt = r_cycle_cnt;
        case (r_state)
            S_IDLE, S_PASS, S_FAIL: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_fail_nxt  = 1'b0;
                    w_code_nxt  = 2'd0;
                    w_match_nxt = '0;
                    w_cycle_nxt = '0;
                end
            end
            S_RUN: begin
                if (r_cycle_cnt != CYC_W'(TIMEOUT)) begin
                    w_cycle_nxt = r_cycle_cnt + CYC_W'(1);
                end
                // Priority: address mismatch, data mismatch, completing match, then timeout.
                if (w_qual && !w_addr_ok) begin
                    w_state_nxt = S_FAIL;
                    w_done_nxt  = 1'b1;
                    w_fail_nxt  = 1'b1;
                    w_code_nxt  = 2'd1;
                end else if (w_qual && !w_data_ok) begin
                    w_state_nxt = S_FAIL;
                    w_done_nxt  = 1'b1;
                    w_fail_nxt  = 1'b1;
                    w_code_nxt  = 2'd2;
                end else if (w_qual && w_last) begin
                    w_state_nxt = S_PASS;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = 1'b1;
                    w_match_nxt = r_match_cnt + CNT_W'(1);
                end else begin
                    if (w_qual) begin
                        w_match_nxt = r_match_cnt + CNT_W'(1);
                    end
                    if (w_tmo) begin
                        w_state_nxt = S_FAIL;
                        w_done_nxt  = 1'b1;
                        w_fail_nxt  = 1'b1;
                        w_code_nxt  = 2'd3;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_code      <= 2'd0;
            r_match_cnt <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail      <= w_fail_nxt;
            r_code      <= w_code_nxt;
            r_match_cnt <= w_match_nxt;
            r_cycle_cnt <= w_cycle_nxt;
        end
    end

    assign done      = r_done;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign fail_code = r_code;
    assign match_cnt = r_match_cnt;
    assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: a single-entry instance for the basic vectors, and a
// four-entry, TIMEOUT=50 instance for timeout/reset corners and randomized traces.
module tb_mem_write_checker;

    localparam int TMO    = 50;
    localparam int TR_LEN = 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exp_we;
    logic [1:0]  exp_idx;
    logic [31:0] exp_addr, exp_data;
    logic        start;
    logic        mem_write;
    logic [31:0] data_adr, write_data;

    logic        d_done, d_pass, d_fail;
    logic [1:0]  d_code;
    logic [2:0]  d_match;
    logic [5:0]  d_cycle;

    logic        s_done, s_pass, s_fail;
    logic [1:0]  s_code;
    logic [0:0]  s_match;
    logic [9:0]  s_cycle;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] tbl_a [4];
    logic [31:0] tbl_d [4];
    bit          tr_we  [TR_LEN];
    logic [31:0] tr_adr [TR_LEN];
    logic [31:0] tr_dat [TR_LEN];

    typedef struct {
        bit          restart;
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        bit          e_done;
        bit          e_pass;
        bit          e_fail;
        int          e_code;
        int          e_match;
        string       name;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    mem_write_checker #(
        .ADDR_W(32), .DATA_W(32), .NUM_EXP(4), .IGNORE_EN(1), .IGNORE_ADDR(96), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(rst_n), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .start(start),
        .MemWrite(mem_write), .DataAdr(data_adr), .WriteData(write_data),
        .done(d_done), .pass(d_pass), .fail(d_fail), .fail_code(d_code),
        .match_cnt(d_match), .cycle_cnt(d_cycle)
    );

    mem_write_checker #(
        .ADDR_W(32), .DATA_W(32), .NUM_EXP(1), .IGNORE_EN(1), .IGNORE_ADDR(96), .TIMEOUT(1000)
    ) dut1 (
        .clk(clk), .reset(rst_n), .exp_we(exp_we), .exp_idx(exp_idx[0:0]),
        .exp_addr(exp_addr), .exp_data(exp_data), .start(start),
        .MemWrite(mem_write), .DataAdr(data_adr), .WriteData(write_data),
        .done(s_done), .pass(s_pass), .fail(s_fail), .fail_code(s_code),
        .match_cnt(s_match), .cycle_cnt(s_cycle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exp_we = 0; exp_idx = 0; exp_addr = 0; exp_data = 0;
        start = 0; mem_write = 0; data_adr = 0; write_data = 0;
    endtask

    task automatic load(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
        exp_we = 1; exp_idx = idx; exp_addr = a; exp_data = d;
        tick();
        exp_we = 0;
    endtask

    task automatic do_start();
        start = 1; mem_write = 0;
        tick();
        start = 0;
    endtask

    task automatic store(input bit we, input logic [31:0] a, input logic [31:0] d);
        mem_write = we; data_adr = a; write_data = d;
        tick();
        mem_write = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #3;
        rst_n = 1;
        tick();
    endtask

    // Outcome of a whole trace from the table rules: index of the deciding cycle, cause, matches.
    function automatic void predict(output int e, output int c, output int m);
        int mm = 0;
        e = TR_LEN; c = 0; m = 0;
        for (int i = 0; i < TR_LEN; i++) begin
            if (tr_we[i] && tr_adr[i] != 32'd96) begin
                if (tr_adr[i] != tbl_a[mm]) begin e = i; c = 1; m = mm; return; end
                if (tr_dat[i] != tbl_d[mm]) begin e = i; c = 2; m = mm; return; end
                mm++;
                if (mm == 4) begin e = i; c = 0; m = mm; return; end
            end
            if (i + 1 == TMO) begin e = i; c = 3; m = mm; return; end
        end
        m = mm;
    endfunction

    function automatic logic [31:0] pick_addr();
        int p = $urandom_range(0, 4);
        return (p == 4) ? 32'd100 : 32'(p * 4);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e, c, m, ptr, p_int, r;
        idle_inputs();
        rst_n = 0;
        #12;
        chk("reset done", d_done, 0);
        chk("reset pass", d_pass, 0);
        chk("reset fail", d_fail, 0);
        chk("reset code", d_code, 0);
        chk("reset match", d_match, 0);
        chk("reset cycle", d_cycle, 0);
        chk("reset s_done", s_done, 0);
        rst_n = 1;
        tick();

        // Single-entry vectors: entry0=(100,25); idx 1 is out of range and must be dropped.
        load(2'd0, 32'd100, 32'd25);
        load(2'd1, 32'd100, 32'd99);
        vecs[0] = '{1, 1, 32'd96,  32'd7,  0, 0, 0, 0, 0, "T1 ignored store"};
        vecs[1] = '{0, 1, 32'd100, 32'd25, 1, 1, 0, 0, 1, "T1 match pass"};
        vecs[2] = '{0, 1, 32'd100, 32'd24, 1, 1, 0, 0, 1, "T1 sticky pass"};
        vecs[3] = '{1, 1, 32'd100, 32'd24, 1, 0, 1, 2, 0, "T2 data mismatch"};
        vecs[4] = '{1, 1, 32'd104, 32'd25, 1, 0, 1, 1, 0, "T3 addr mismatch"};
        vecs[5] = '{1, 1, 32'd104, 32'd0,  1, 0, 1, 1, 0, "T3 addr priority"};
        vecs[6] = '{1, 0, 32'd100, 32'd25, 0, 0, 0, 0, 0, "no strobe"};
        vecs[7] = '{0, 1, 32'd96,  32'd99, 0, 0, 0, 0, 0, "scratch store"};
        vecs[8] = '{0, 1, 32'd100, 32'd25, 1, 1, 0, 0, 1, "pass after idle"};
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].restart) do_start();
            store(vecs[i].we, vecs[i].adr, vecs[i].dat);
            chk({vecs[i].name, " done"},  s_done,  vecs[i].e_done);
            chk({vecs[i].name, " pass"},  s_pass,  vecs[i].e_pass);
            chk({vecs[i].name, " fail"},  s_fail,  vecs[i].e_fail);
            chk({vecs[i].name, " code"},  s_code,  vecs[i].e_code);
            chk({vecs[i].name, " match"}, s_match, vecs[i].e_match);
        end

        // T4: timeout after exactly TMO RUN cycles.
        do_reset();
        do_start();
        for (int i = 0; i < TMO - 1; i++) store(0, 0, 0);
        chk("T4 no fail before timeout", d_fail, 0);
        chk("T4 cycle before timeout", d_cycle, TMO - 1);
        store(0, 0, 0);
        chk("T4 fail", d_fail, 1);
        chk("T4 done", d_done, 1);
        chk("T4 code", d_code, 3);
        chk("T4 cycle", d_cycle, TMO);

        // T5: four-entry table with interleaved scratch stores.
        tbl_a = '{32'd0, 32'd4, 32'd8, 32'd12};
        tbl_d = '{32'd1, 32'd2, 32'd3, 32'd4};
        for (int i = 0; i < 4; i++) load(2'(i), tbl_a[i], tbl_d[i]);
        do_start();
        for (int i = 0; i < 4; i++) begin
            store(1, 32'd96, 32'(i + 50));
            store(1, tbl_a[i], tbl_d[i]);
        end
        chk("T5 pass", d_pass, 1);
        chk("T5 match", d_match, 4);
        chk("T5 code", d_code, 0);

        do_start();
        store(1, tbl_a[0], tbl_d[0]);
        store(1, tbl_a[1], tbl_d[1]);
        chk("T5 match before reset", d_match, 2);
        #2;
        rst_n = 0;
        #1;
        chk("T5 async reset match", d_match, 0);
        chk("T5 async reset cycle", d_cycle, 0);
        chk("T5 async reset done", d_done, 0);
        @(negedge clk);
        rst_n = 1;
        tick();
        do_start();
        for (int i = 0; i < 3; i++) store(1, tbl_a[i], tbl_d[i]);
        chk("T5 restart needs all four", d_done, 0);
        store(1, tbl_a[3], tbl_d[3]);
        chk("T5 restart pass", d_pass, 1);

        // T6: final match on the timeout cycle; table write during RUN is dropped.
        do_start();
        exp_we = 1; exp_idx = 0; exp_addr = 32'd200; exp_data = 32'd200;
        store(1, tbl_a[0], tbl_d[0]);
        exp_we = 0;
        store(1, tbl_a[1], tbl_d[1]);
        store(1, tbl_a[2], tbl_d[2]);
        for (int i = 3; i < TMO - 1; i++) store(0, 0, 0);
        chk("T6 not done before last", d_done, 0);
        store(1, tbl_a[3], tbl_d[3]);
        chk("T6 pass on timeout cycle", d_pass, 1);
        chk("T6 fail on timeout cycle", d_fail, 0);
        chk("T6 cycle", d_cycle, TMO);
        do_start();
        for (int i = 0; i < 4; i++) store(1, tbl_a[i], tbl_d[i]);
        chk("T6 table unchanged", d_pass, 1);

        // Randomized traces against the trace-level prediction.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) begin
                tbl_a[i] = pick_addr();
                tbl_d[i] = 32'($urandom_range(0, 3));
                load(2'(i), tbl_a[i], tbl_d[i]);
            end
            p_int = ($urandom_range(0, 3) == 0) ? 8 : 45;
            ptr = 0;
            for (int i = 0; i < TR_LEN; i++) begin
                r = $urandom_range(0, 99);
                if (r < 30) begin
                    tr_we[i] = 0; tr_adr[i] = pick_addr(); tr_dat[i] = 0;
                end else if (r < 45) begin
                    tr_we[i] = 1; tr_adr[i] = 32'd96; tr_dat[i] = $urandom;
                end else if (r < 45 + p_int) begin
                    tr_we[i] = 1; tr_adr[i] = tbl_a[ptr]; tr_dat[i] = tbl_d[ptr];
                    if (ptr < 3) ptr++;
                end else begin
                    tr_we[i] = 1; tr_adr[i] = pick_addr(); tr_dat[i] = 32'($urandom_range(0, 3));
                end
            end
            predict(e, c, m);
            do_start();
            for (int i = 0; i < TR_LEN; i++) begin
                store(tr_we[i], tr_adr[i], tr_dat[i]);
                chk($sformatf("rand%0d done@%0d", t, i), d_done, (i >= e) ? 1 : 0);
            end
            chk($sformatf("rand%0d pass", t), d_pass, (c == 0) ? 1 : 0);
            chk($sformatf("rand%0d fail", t), d_fail, (c != 0) ? 1 : 0);
            chk($sformatf("rand%0d code", t), d_code, c);
            chk($sformatf("rand%0d match", t), d_match, m);
            chk($sformatf("rand%0d cycle", t), d_cycle, e + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
